// File: rtl/multi_freq_counter.sv
// multi_freq_counter
// Measures high time, low time and rising-to-rising period of NUM_CH
// asynchronous inputs in CLK cycles. Each channel has its own synchroniser,
// saturating counters, stale/timeout flag, valid strobes and a
// power-of-two period average. Channels share nothing but CLK, RST_N and EN.
// SYNC_STAGES must be at least 2.
module multi_freq_counter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic [NUM_CH-1:0]       FREQ_IN,
  output logic [NUM_CH*CNT_W-1:0] TIME_HIGH,
  output logic [NUM_CH*CNT_W-1:0] TIME_LOW,
  output logic [NUM_CH*CNT_W-1:0] PERIOD,
  output logic [NUM_CH*CNT_W-1:0] PERIOD_AVG,
  output logic [NUM_CH-1:0]       VALID,
  output logic [NUM_CH-1:0]       AVG_VALID,
  output logic [NUM_CH-1:0]       STALE
);

  // The accumulator holds up to 2^AVG_LOG2 full-scale periods without overflow.
  localparam int ACC_W = CNT_W + AVG_LOG2;
  // Averaging slot counter needs at least one bit even when AVG_LOG2 is 0.
  localparam int AC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AVG_N = 1 << AVG_LOG2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating increment: sticks at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Power-of-two mean with truncation toward zero.
  function automatic logic [CNT_W-1:0] avg_div(input logic [ACC_W-1:0] a);
    return CNT_W'(a >> AVG_LOG2);
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p1;
    logic                   s;
    logic                   rise;
    logic                   fall;

    logic [CNT_W-1:0]       hi_cnt;
    logic [CNT_W-1:0]       lo_cnt;
    logic [CNT_W-1:0]       per_cnt;
    logic [ACC_W-1:0]       acc;
    logic [AC_W-1:0]        avg_cnt;
    logic                   armed;

    logic [CNT_W-1:0]       th_q;
    logic [CNT_W-1:0]       tl_q;
    logic [CNT_W-1:0]       per_q;
    logic [CNT_W-1:0]       avg_q;
    logic                   vld_p1;
    logic                   avld_p1;
    logic                   stale_q;

    logic                   timeout;
    logic                   avg_last;
    logic [ACC_W-1:0]       acc_sum;

    // s is the last synchroniser flop; s_p1 is s one cycle later.
    assign s        = sync_p0[SYNC_STAGES-1];
    assign rise     = s & ~s_p1;
    assign fall     = ~s & s_p1;
    // A full-scale period counter means the input has gone quiet too long.
    assign timeout  = (per_cnt == CNT_MAX);
    assign avg_last = (avg_cnt == AC_W'(AVG_N - 1));
    assign acc_sum  = acc + ACC_W'(per_cnt);

    // Input synchroniser and edge-detect delay; runs whether or not EN is set.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        sync_p0 <= '0;
        s_p1    <= 1'b0;
      end else begin
        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], FREQ_IN[c]};
        s_p1    <= s;
      end
    end

    // Saturating high/low/period counters; restarted on the edges that begin each interval.
    always_ff @(posedge CLK) begin
      if (!RST_N || !EN) begin
        hi_cnt  <= '0;
        lo_cnt  <= '0;
        per_cnt <= '0;
      end else if (rise) begin
        hi_cnt  <= CNT_W'(1);
        per_cnt <= CNT_W'(1);
      end else if (fall) begin
        lo_cnt  <= CNT_W'(1);
        per_cnt <= sat_inc(per_cnt);
      end else begin
        per_cnt <= sat_inc(per_cnt);
        if (s) begin
          hi_cnt <= sat_inc(hi_cnt);
        end else begin
          lo_cnt <= sat_inc(lo_cnt);
        end
      end
    end

    // Arm/timeout control, result capture, averaging and one-cycle strobes.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        armed   <= 1'b0;
        acc     <= '0;
        avg_cnt <= '0;
        th_q    <= '0;
        tl_q    <= '0;
        per_q   <= '0;
        avg_q   <= '0;
        vld_p1  <= 1'b0;
        avld_p1 <= 1'b0;
        stale_q <= 1'b0;
      end else begin
        vld_p1  <= 1'b0;
        avld_p1 <= 1'b0;
        if (!EN) begin
          armed   <= 1'b0;
          acc     <= '0;
          avg_cnt <= '0;
        end else if (timeout) begin
          // Results hold; a rise in this same cycle still counts as the re-arming rise.
          stale_q <= 1'b1;
          armed   <= rise;
          acc     <= '0;
          avg_cnt <= '0;
        end else begin
          if (rise) begin
            armed <= 1'b1;
            if (armed) begin
              tl_q    <= lo_cnt;
              per_q   <= per_cnt;
              vld_p1  <= 1'b1;
              stale_q <= 1'b0;
              if (avg_last) begin
                avg_q   <= avg_div(acc_sum);
                avld_p1 <= 1'b1;
                acc     <= '0;
                avg_cnt <= '0;
              end else begin
                acc     <= acc_sum;
                avg_cnt <= avg_cnt + AC_W'(1);
              end
            end
          end
          if (fall && armed) begin
            th_q <= hi_cnt;
          end
        end
      end
    end

    assign TIME_HIGH[c*CNT_W +: CNT_W]  = th_q;
    assign TIME_LOW[c*CNT_W +: CNT_W]   = tl_q;
    assign PERIOD[c*CNT_W +: CNT_W]     = per_q;
    assign PERIOD_AVG[c*CNT_W +: CNT_W] = avg_q;
    assign VALID[c]                     = vld_p1;
    assign AVG_VALID[c]                 = avld_p1;
    assign STALE[c]                     = stale_q;

  end : g_ch

endmodule

// File: doc/multi_freq_counter.md
Name: multi_freq_counter

Overview:
- Parametrised multi-channel successor to the single-channel high/low/period counter.
- Measures high time, low time and rising-to-rising period of NUM_CH asynchronous digital inputs, in CLK cycles.
- Per channel it adds input synchronisation, saturating counters, a stale/timeout flag, valid strobes and a power-of-two period average.
- Sits between the ring-oscillator / frequency modules and the readout mux.

Parameters:
- NUM_CH, 4: number of independent input channels.
- CNT_W, 24: width of every count/result field.
- SYNC_STAGES, 2: synchroniser flops per input; minimum 2.
- AVG_LOG2, 2: the average covers 2^AVG_LOG2 periods; 0 means PERIOD_AVG equals PERIOD.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, synchronous, active-low.
- EN  in  1  measurement enable.
- FREQ_IN  in  NUM_CH  asynchronous signals to measure; bit c is channel c.
- TIME_HIGH  out  NUM_CH*CNT_W  last high duration; channel c at bits [c*CNT_W +: CNT_W].
- TIME_LOW  out  NUM_CH*CNT_W  last low duration.
- PERIOD  out  NUM_CH*CNT_W  last rising-to-rising period.
- PERIOD_AVG  out  NUM_CH*CNT_W  mean of the last 2^AVG_LOG2 periods, truncated.
- VALID  out  NUM_CH  1-cycle pulse when PERIOD updates.
- AVG_VALID  out  NUM_CH  1-cycle pulse when PERIOD_AVG updates.
- STALE  out  NUM_CH  level flag: period counter saturated with no valid period since.

Behaviour:
- Reset (RST_N=0 at a CLK edge): all outputs, synchronisers, counters, accumulators and arm flags go to 0. This applies mid-measurement as well.
- Synchroniser: s_c is the output of the last sync flop; p_c is s_c delayed by one cycle.
  - rise = s_c & ~p_c; fall = ~s_c & p_c.
  - The synchroniser runs regardless of EN.
- Per-channel counters: hi_cnt, lo_cnt, per_cnt, each CNT_W bits and saturating at 2^CNT_W-1 (no wrap).
  - Non-edge cycle: hi_cnt increments if s_c=1, else lo_cnt increments. per_cnt always increments.
  - On rise: hi_cnt<=1, per_cnt<=1.
  - On fall: lo_cnt<=1.
- Arm flag: armed_c is set on the first rise after reset or enable. Result updates require armed_c=1 before the edge.
- On rise with armed_c=1:
  - TIME_LOW<=lo_cnt; PERIOD<=per_cnt; VALID_c=1 in the following cycle.
  - STALE_c<=0.
  - Averaging: acc<=acc+per_cnt and avg_cnt++. acc is CNT_W+AVG_LOG2 bits.
  - When avg_cnt reaches 2^AVG_LOG2-1 before this edge: PERIOD_AVG<=(acc+per_cnt)>>AVG_LOG2, AVG_VALID_c pulses, acc<=0, avg_cnt<=0.
- On fall with armed_c=1: TIME_HIGH<=hi_cnt. No strobe.
- Result: a square wave high H, low L gives TIME_HIGH=H, TIME_LOW=L, PERIOD=H+L.
- Latency: if FREQ_IN is first sampled high at edge k, outputs and VALID are updated by edge k+SYNC_STAGES.
- Saturation/timeout: when per_cnt reaches 2^CNT_W-1:
  - STALE_c<=1, armed_c<=0, acc/avg_cnt<=0.
  - Outputs hold.
  - The next rise re-arms; the following rise produces VALID and clears STALE.
  - A saturated hi_cnt or lo_cnt on a still-armed channel reports the max value.
- EN=0: per-channel counters, arm flags and accumulators are held at 0. Outputs and STALE hold; no strobes.
- EN 0->1: behaves as after reset but keeps output values.
- Channels are fully independent. Simultaneous edges on several channels in one cycle are all processed that cycle.

Test Plan:
- NUM_CH=2, CNT_W=8, SYNC_STAGES=2, AVG_LOG2=2 throughout.
- Ch0 square wave 3 high/5 low, EN=1 -> first rise gives no VALID. Second rise: VALID[0] pulse, PERIOD=8, TIME_LOW=5, TIME_HIGH=3 (from the preceding fall). Fifth rise: AVG_VALID[0], PERIOD_AVG=8.
- Ch0 periods alternating 6,10 (high 3) -> PERIOD alternates 6/10. PERIOD_AVG=8 at each AVG_VALID, every 4th VALID.
- Ch0 held low 300 cycles after arming -> STALE[0]=1 once per_cnt reaches 255, outputs unchanged. Resume 8-cycle wave -> re-arm on 1st rise; VALID with PERIOD=8 and STALE=0 on 2nd rise.
- Ch0 period 8, ch1 period 12, with coincident rises on the same cycle -> both VALID bits pulse the same cycle. PERIOD fields 8 and 12, no crosstalk.
- RST_N low for 1 cycle mid-period -> all outputs 0 next cycle. No VALID until the second rise after reset.
- EN dropped for 20 cycles mid-period -> no strobes, outputs hold. After re-enable, the first VALID comes on the second rise and reports a clean period of 8.
